// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: buffers 3-bit codes in a small FIFO and replays
// each one as a timed one-hot pulse followed by one idle gap cycle.
module onehot_pulse_decoder #(
    parameter  int DEPTH  = 4,
    parameter  int HOLD_W = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_code,
    input  logic              in_en,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [7:0]        y_decoder,
    output logic              out_valid,
    output logic              busy,
    output logic [AW:0]       level
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [7:0]        y_q, y_d;

    logic [3:0]        mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              full, empty;
    logic              push, pop;
    logic [3:0]        head;
    logic [7:0]        head_y;

    // Wrap bit differs and index bits match: the ring is full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && !empty;

    assign head   = mem[rd_ptr[AW-1:0]];
    assign head_y = head[3] ? (8'(1) << head[2:0]) : 8'h00;

    assign level     = wr_ptr - rd_ptr;
    assign out_valid = (state_q == ACTIVE);
    assign busy      = (state_q != IDLE) || !empty;
    assign y_decoder = y_q;

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_en, in_code};
        end
    end

    // FIFO pointers advance independently on push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Slot sequencer registers: state, hold counter and output pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    // Next slot state: load on pop, count down, then one blank gap cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    cnt_d   = hold_cycles;
                    y_d     = head_y;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    y_d     = 8'h00;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            GAP: begin
                y_d     = 8'h00;
                state_d = IDLE;
            end
            default: begin
                y_d     = 8'h00;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder: a queue-and-timer model is checked
// every cycle, plus literal expectations per directed scenario.
module tb_onehot_pulse_decoder;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_en = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic [3:0] hold_cycles = 4'd0;
    logic       in_ready;
    logic [7:0] y_decoder;
    logic       out_valid;
    logic       busy;
    logic [2:0] level;

    int n_cmp = 0;
    int n_bad = 0;
    int ecount = 0;
    bit chk_on = 1'b0;

    onehot_pulse_decoder #(
        .DEPTH (DEPTH),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .hold_cycles(hold_cycles),
        .y_decoder  (y_decoder),
        .out_valid  (out_valid),
        .busy       (busy),
        .level      (level)
    );

    always #5 clk = ~clk;

    // clock edge counter used to time pulses
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // model: FIFO as a queue; a pop starts h+1 active cycles and the next
    // pop may happen h+3 edges later
    logic [3:0] mq[$];
    int         act_left = 0;
    int         cool = 0;
    logic [7:0] m_pat = 8'h00;
    bit         m_dp;
    logic [3:0] m_h;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            act_left = 0;
            cool = 0;
            m_pat = 8'h00;
        end else begin
            m_dp = in_valid && (mq.size() < DEPTH);
            if (act_left > 0) act_left--;
            if (cool > 0) cool--;
            if (cool == 0 && mq.size() > 0) begin
                m_h = mq.pop_front();
                m_pat = m_h[3] ? (8'h01 << m_h[2:0]) : 8'h00;
                act_left = int'(hold_cycles) + 1;
                cool = act_left + 2;
            end
            if (m_dp) mq.push_back({in_en, in_code});
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("y_decoder", 32'(y_decoder),
                32'(act_left > 0 ? m_pat : 8'h00));
            chk("out_valid", 32'(out_valid), 32'(act_left > 0));
            chk("busy", 32'(busy), 32'(mq.size() > 0 || cool > 1));
            chk("level", 32'(level), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(!rst && mq.size() < DEPTH));
        end
    end

    // record nonzero pulses: value, start edge, length
    logic [7:0] seen_v[$];
    int         seen_t[$];
    int         seen_l[$];
    logic [7:0] prev_y = 8'h00;

    always @(negedge clk) begin
        if (y_decoder != 8'h00 && prev_y == 8'h00) begin
            seen_v.push_back(y_decoder);
            seen_t.push_back(ecount);
            seen_l.push_back(1);
        end else if (y_decoder != 8'h00) begin
            seen_l[seen_l.size()-1] = seen_l[seen_l.size()-1] + 1;
        end
        prev_y = y_decoder;
    end

    task automatic clear_seen();
        seen_v.delete();
        seen_t.delete();
        seen_l.delete();
    endtask

    task automatic push(input logic [2:0] c, input logic en, output int acc);
        bit ok;
        int n;
        in_code = c;
        in_en = en;
        in_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        acc = ecount;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got no in_ready expected accept");
        end
    endtask

    task automatic wait_idle();
        int n;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || out_valid) && n < 300);
        if (busy || out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(posedge clk);
        #2;
    endtask

    int         acc;
    int         ov_n;
    int         nz_n;
    logic [2:0] bp_codes[6];
    logic [7:0] exp_q[$];
    logic [2:0] rc;
    logic       re;

    initial begin
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_init", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // hold length, hold_cycles changed mid-pulse
        clear_seen();
        hold_cycles = 4'd3;
        push(3'd5, 1'b1, acc);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 hold_cycles = 4'd0;
        wait_idle();
        chk("hold_count", 32'(seen_v.size()), 32'd1);
        if (seen_v.size() == 1) begin
            chk("hold_value", 32'(seen_v[0]), 32'h20);
            chk("hold_start", 32'(seen_t[0] - acc), 32'd1);
            chk("hold_len", 32'(seen_l[0]), 32'd4);
        end

        // full sweep, hold 0
        clear_seen();
        hold_cycles = 4'd0;
        for (int i = 0; i < 8; i++) push(3'(i), 1'b1, acc);
        wait_idle();
        chk("sweep_count", 32'(seen_v.size()), 32'd8);
        if (seen_v.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("sweep_value", 32'(seen_v[i]), 32'(1 << i));
                chk("sweep_len", 32'(seen_l[i]), 32'd1);
                if (i > 0) chk("sweep_period", 32'(seen_t[i] - seen_t[i-1]), 32'd3);
            end
        end

        // blank slot
        hold_cycles = 4'd2;
        push(3'd6, 1'b0, acc);
        in_valid = 1'b0;
        ov_n = 0;
        nz_n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) ov_n++;
            if (y_decoder != 8'h00) nz_n++;
        end
        chk("blank_ov_len", 32'(ov_n), 32'd3);
        chk("blank_y_zero", 32'(nz_n), 32'd0);
        wait_idle();

        // backpressure
        clear_seen();
        hold_cycles = 4'd15;
        bp_codes = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd4};
        for (int i = 0; i < 5; i++) push(bp_codes[i], 1'b1, acc);
        @(negedge clk);
        chk("bp_level", 32'(level), 32'd4);
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_one_pop", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        push(bp_codes[5], 1'b1, acc);
        wait_idle();
        chk("bp_count", 32'(seen_v.size()), 32'd6);
        if (seen_v.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("bp_order", 32'(seen_v[i]), 32'(1 << bp_codes[i]));
                chk("bp_len", 32'(seen_l[i]), 32'd16);
            end
        end

        // random stream with gaps across pointer wrap
        clear_seen();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            rc = 3'($urandom_range(0, 7));
            re = 1'($urandom_range(0, 3) != 0);
            hold_cycles = 4'($urandom_range(0, 2));
            push(rc, re, acc);
            if (re) exp_q.push_back(8'h01 << rc);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
        end
        wait_idle();
        chk("wrap_count", 32'(seen_v.size()), 32'(exp_q.size()));
        if (seen_v.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                chk("wrap_order", 32'(seen_v[i]), 32'(exp_q[i]));
        end

        // reset mid-stream with level 3 and an active slot
        hold_cycles = 4'd15;
        for (int i = 0; i < 4; i++) push(3'(i), 1'b1, acc);
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_active", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_y", 32'(y_decoder), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 32'd1);
        chk("rel_y", 32'(y_decoder), 32'h00);
        repeat (3) @(negedge clk);
        chk("rel_no_gap_pulse", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
